// File: rtl/counter_next.sv
// Next-state and terminal-count logic for one counter_sync slice.
// Purely combinational: the register and async clear live in counter_sync.
`ifndef COUNTER_NEXT_SV
`define COUNTER_NEXT_SV

module counter_next #(
  parameter int BITS = 4
) (
  input  logic [BITS-1:0] q,
  input  logic            up,
  input  logic [BITS-1:0] d,
  input  logic            load,
  input  logic            en,
  output logic [BITS-1:0] q_next,
  output logic            tc
);

  localparam logic [BITS-1:0] ALL_ONES = '1;

  // NOTE: every output gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    q_next = q;
    tc     = up ? (q == ALL_ONES) : (q == '0);
    if (load) begin
      q_next = d;
    end else if (en) begin
      q_next = up ? q + 1'b1 : q - 1'b1;
    end
  end

endmodule

`endif

// File: rtl/counter_sync.sv
// Cascadable up/down binary counter with synchronous load and ripple-carry out.
// Chain rco into the next slice's ent to build wider counters.
`ifndef COUNTER_SYNC_SV
`define COUNTER_SYNC_SV

module counter_sync #(
  parameter int BITS = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            load,
  input  logic [BITS-1:0] d,
  input  logic            enp,
  input  logic            ent,
  input  logic            up,
  output logic [BITS-1:0] q,
  output logic            rco
);

  logic [BITS-1:0] q_next;
  logic            tc;

  counter_next #(.BITS(BITS)) u_next (
    .q      (q),
    .up     (up),
    .d      (d),
    .load   (load),
    .en     (enp & ent),
    .q_next (q_next),
    .tc     (tc)
  );

  // NOTE: state registers use non-blocking assignments; the clear sits in the
  // sensitivity list so q drops as soon as reset_n falls, without a clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else begin
      q <= q_next;
    end
  end

  // Left combinational so a cascade settles within one clock period.
  assign rco = ent & tc;

`ifdef FORMAL
  logic past_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      past_valid <= 1'b0;
    end else begin
      past_valid <= 1'b1;
    end
  end

  always_comb begin
    if (!reset_n) begin
      assert (q == '0);
    end
    assert (rco == (ent & (up ? (q == {BITS{1'b1}}) : (q == '0))));
  end

  always @(posedge clk) begin
    if (past_valid && reset_n && $past(reset_n)) begin
      if ($past(load)) begin
        assert (q == $past(d));
      end else if ($past(enp & ent)) begin
        assert (q == ($past(up) ? $past(q) + 1'b1 : $past(q) - 1'b1));
      end else begin
        assert (q == $past(q));
      end
    end
  end
`endif

endmodule

`endif

// File: tb/tb_counter_sync.sv
// Self-checking bench for counter_sync: directed scenarios plus randomized
// traffic against an arithmetic model of a modulo-2^BITS up/down counter.
module tb_counter_sync;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       load, enp, ent, up;
  logic [3:0] d;
  logic [3:0] q;
  logic       rco;
  logic [0:0] q1;
  logic       rco1;

  // Two-slice cascade: lower rco drives upper ent.
  logic       c_load, c_enp, c_up;
  logic [7:0] c_d;
  logic [3:0] c_qlo, c_qhi;
  logic       c_rlo, c_rhi;

  int checks = 0;
  int errors = 0;
  int exp_q, exp_q1, exp_c;

  always #5 clk = ~clk;

  counter_sync #(.BITS(4)) u_dut (
    .clk(clk), .reset_n(reset_n), .load(load), .d(d), .enp(enp), .ent(ent),
    .up(up), .q(q), .rco(rco)
  );

  counter_sync #(.BITS(1)) u_one (
    .clk(clk), .reset_n(reset_n), .load(load), .d(d[0:0]), .enp(enp), .ent(ent),
    .up(up), .q(q1), .rco(rco1)
  );

  counter_sync #(.BITS(4)) u_lo (
    .clk(clk), .reset_n(reset_n), .load(c_load), .d(c_d[3:0]), .enp(c_enp),
    .ent(1'b1), .up(c_up), .q(c_qlo), .rco(c_rlo)
  );

  counter_sync #(.BITS(4)) u_hi (
    .clk(clk), .reset_n(reset_n), .load(c_load), .d(c_d[7:4]), .enp(c_enp),
    .ent(c_rlo), .up(c_up), .q(c_qhi), .rco(c_rhi)
  );

  // Reference: a counter modulo m that loads, steps by +/-1, or holds.
  function automatic int model_next(int cur, int m, bit ld, int dv, bit en, bit u);
    if (ld) return dv % m;
    if (en) return u ? (cur + 1) % m : (cur + m - 1) % m;
    return cur;
  endfunction

  function automatic bit model_rco(int cur, int m, bit e, bit u);
    return e && (u ? (cur == m - 1) : (cur == 0));
  endfunction

  // One clock: advance the models from the inputs present at the edge,
  // then let outputs settle before anyone samples them.
  task automatic tick();
    exp_q  = model_next(exp_q, 16, load, int'(d), enp && ent, up);
    exp_q1 = model_next(exp_q1, 2, load, int'(d[0]), enp && ent, up);
    exp_c  = model_next(exp_c, 256, c_load, int'(c_d), c_enp, c_up);
    @(posedge clk);
    #1;
  endtask

  task automatic check_main(string name);
    checks++;
    if (q !== 4'(exp_q)) begin
      errors++;
      $display("FAIL %s q got %h want %h", name, q, 4'(exp_q));
    end
    checks++;
    if (rco !== model_rco(exp_q, 16, ent, up)) begin
      errors++;
      $display("FAIL %s rco got %b want %b (q=%h ent=%b up=%b)", name, rco,
               model_rco(exp_q, 16, ent, up), q, ent, up);
    end
  endtask

  task automatic test_reset();
    load = 1'b1; d = 4'h9; enp = 1'b0; ent = 1'b1; up = 1'b0;
    tick();
    load = 1'b0;
    check_main("reset_preload");
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    exp_q = 0; exp_q1 = 0; exp_c = 0;
    checks++;
    if (q !== 4'h0) begin errors++; $display("FAIL reset_async q got %h want 0", q); end
    checks++;
    if (rco !== 1'b1) begin errors++; $display("FAIL reset_rco_down got %b want 1", rco); end
    up = 1'b1;
    #1;
    checks++;
    if (rco !== 1'b0) begin errors++; $display("FAIL reset_rco_up got %b want 0", rco); end
    // A load presented during reset must be discarded.
    load = 1'b1; d = 4'h5; enp = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (q !== 4'h0) begin errors++; $display("FAIL reset_hold q got %h want 0", q); end
    load = 1'b0; enp = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check_main("reset_release");
  endtask

  task automatic test_up_wrap();
    load = 1'b1; d = 4'hD; enp = 1'b1; ent = 1'b1; up = 1'b1;
    tick();
    load = 1'b0;
    check_main("up_load_d");
    for (int i = 0; i < 4; i++) begin
      tick();
      check_main($sformatf("up_wrap_%0d", i));
    end
    load = 1'b1; d = 4'hF;
    tick();
    load = 1'b0; ent = 1'b0;
    #1;
    check_main("up_rco_ent0_at_f");
  endtask

  task automatic test_down_wrap();
    load = 1'b1; d = 4'h2; enp = 1'b1; ent = 1'b1; up = 1'b0;
    tick();
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_main($sformatf("down_wrap_%0d", i));
    end
  endtask

  task automatic test_load_priority();
    load = 1'b1; d = 4'h3; enp = 1'b0; ent = 1'b1; up = 1'b1;
    tick();
    load = 1'b1; d = 4'hA; enp = 1'b1;
    tick();
    check_main("load_wins");
    load = 1'b0;
    tick();
    check_main("load_then_count");
  endtask

  task automatic test_enable_gating();
    load = 1'b1; d = 4'hF; enp = 1'b1; ent = 1'b1; up = 1'b1;
    tick();
    load = 1'b0; enp = 1'b0; ent = 1'b1;
    tick();
    check_main("gate_enp0");
    enp = 1'b1; ent = 1'b0;
    tick();
    check_main("gate_ent0");
  endtask

  task automatic test_cascade();
    c_load = 1'b1; c_d = 8'hFE; c_enp = 1'b0; c_up = 1'b1;
    tick();
    c_load = 1'b0; c_enp = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({c_qhi, c_qlo} !== 8'(exp_c)) begin
        errors++;
        $display("FAIL cascade_%0d got %h want %h", i, {c_qhi, c_qlo}, 8'(exp_c));
      end
    end
    c_enp = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      load = ($urandom_range(0, 7) == 0);
      enp  = ($urandom_range(0, 3) != 0);
      ent  = ($urandom_range(0, 3) != 0);
      up   = 1'($urandom);
      d    = 4'($urandom);
      c_load = ($urandom_range(0, 15) == 0);
      c_d    = 8'($urandom);
      c_enp  = ($urandom_range(0, 3) != 0);
      c_up   = 1'($urandom);
      if ($urandom_range(0, 49) == 0) begin
        reset_n = 1'b0;
        #1;
        exp_q = 0; exp_q1 = 0; exp_c = 0;
        checks++;
        if (q !== 4'h0) begin errors++; $display("FAIL rand_reset q got %h want 0", q); end
        reset_n = 1'b1;
      end
      tick();
      check_main($sformatf("rand_%0d", i));
      checks++;
      if (q1 !== 1'(exp_q1) || rco1 !== model_rco(exp_q1, 2, ent, up)) begin
        errors++;
        $display("FAIL rand1_%0d q1/rco1 got %b/%b want %b/%b", i, q1, rco1,
                 1'(exp_q1), model_rco(exp_q1, 2, ent, up));
      end
      checks++;
      if ({c_qhi, c_qlo} !== 8'(exp_c)) begin
        errors++;
        $display("FAIL randc_%0d got %h want %h", i, {c_qhi, c_qlo}, 8'(exp_c));
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    load = 1'b0; enp = 1'b0; ent = 1'b0; up = 1'b0; d = '0;
    c_load = 1'b0; c_enp = 1'b0; c_up = 1'b1; c_d = '0;
    exp_q = 0; exp_q1 = 0; exp_c = 0;
    #12;
    reset_n = 1'b1;
    #1;
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_load_priority();
    test_enable_gating();
    test_cascade();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
